// File: rtl/gt_cache_pkg.sv
// gt_cache_pkg: shared FSM state encoding and address-field widths
// for the set-associative byte-read cache.
package gt_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        VIC_PROBE,
        MEM_REQ,
        MEM_WAIT,
        FILL
    } cacheState_t;

    function automatic int offW(input int lineBytes);
        return $clog2(lineBytes);
    endfunction

    function automatic int idxW(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagW(input int addrW, input int sets,
                                input int lineBytes);
        return addrW - $clog2(sets) - $clog2(lineBytes);
    endfunction

endpackage

// File: rtl/gt_cache_lru.sv
// gt_cache_lru: per-set true-LRU ordering kept as way ages
// (0 = most recent, WAYS-1 = least recent).
module gt_cache_lru
    import gt_cache_pkg::*;
#(
    parameter int SETS = 16,
    parameter int WAYS = 2,
    localparam int IDX_W = idxW(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             touchEn,
    input  logic [IDX_W-1:0] touchSet,
    input  logic [WAY_W-1:0] touchWay,
    input  logic [IDX_W-1:0] querySet,
    output logic [WAY_W-1:0] victimWay
);

    logic [WAY_W-1:0] age [SETS][WAYS];

    // Ages form a permutation per set; reset starts from the identity.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else if (touchEn) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touchWay) begin
                    age[touchSet][w] <= '0;
                end else if (age[touchSet][w] < age[touchSet][touchWay]) begin
                    age[touchSet][w] <= age[touchSet][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victimWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[querySet][w] == WAY_W'(WAYS - 1)) begin
                victimWay = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/gt_assoc_cache.sv
// gt_assoc_cache: blocking set-associative byte-read cache with LRU refill.
// Define GT_ASSOC_CACHE_VICTIM_EN to probe a victim cache before memory.
module gt_assoc_cache
    import gt_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    output logic [7:0]              resp_data,
    output logic                    resp_hit,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_fill_valid,
    input  logic [LINE_BYTES*8-1:0] mem_fill_data,
    output logic                    evict_valid,
    output logic [ADDR_W-1:0]       evict_addr,
    output logic [LINE_BYTES*8-1:0] evict_data,
    output logic                    vic_probe,
    input  logic                    vic_hit,
    input  logic [LINE_BYTES*8-1:0] vic_data
);

    localparam int OFF_W  = offW(LINE_BYTES);
    localparam int IDX_W  = idxW(SETS);
    localparam int TAG_W  = tagW(ADDR_W, SETS, LINE_BYTES);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    cacheState_t state, stateNext;

    logic [ADDR_W-1:0] addrQ;
    logic [LINE_W-1:0] lineQ;

    logic              validQ [SETS][WAYS];
    logic [TAG_W-1:0]  tagQ   [SETS][WAYS];
    logic [LINE_W-1:0] dataQ  [SETS][WAYS];

    logic              respValidQ, respHitQ;
    logic [7:0]        respDataQ;
    logic              evictValidQ;
    logic [ADDR_W-1:0] evictAddrQ;
    logic [LINE_W-1:0] evictDataQ;

    logic [OFF_W-1:0]  reqOff;
    logic [IDX_W-1:0]  reqIdx;
    logic [TAG_W-1:0]  reqTag;
    logic [ADDR_W-1:0] lineAddr;

    logic              hitAny;
    logic [WAY_W-1:0]  hitWay, fillWay, lruWay;
    logic              touchEn;
    logic [WAY_W-1:0]  touchWay;

    assign reqOff   = addrQ[OFF_W-1:0];
    assign reqIdx   = addrQ[OFF_W +: IDX_W];
    assign reqTag   = addrQ[ADDR_W-1 -: TAG_W];
    assign lineAddr = {reqTag, reqIdx, {OFF_W{1'b0}}};

    function automatic logic [7:0] getByte(input logic [LINE_W-1:0] line,
                                           input logic [OFF_W-1:0]  off);
        return line[{off, 3'b000} +: 8];
    endfunction

    always_comb begin
        hitAny = 1'b0;
        hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (validQ[reqIdx][w] && tagQ[reqIdx][w] == reqTag) begin
                hitAny = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins; otherwise fall back to LRU.
    always_comb begin
        fillWay = lruWay;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validQ[reqIdx][w]) begin
                fillWay = WAY_W'(w);
            end
        end
    end

    assign touchEn  = (state == LOOKUP && hitAny) || state == FILL;
    assign touchWay = (state == FILL) ? fillWay : hitWay;

    gt_cache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) uLru (
        .CLK       (CLK),
        .RST       (RST),
        .touchEn   (touchEn),
        .touchSet  (reqIdx),
        .touchWay  (touchWay),
        .querySet  (reqIdx),
        .victimWay (lruWay)
    );

`ifdef GT_ASSOC_CACHE_VICTIM_EN
    // VIC_PROBE spans two cycles: probe, then sample vic_hit.
    logic probedQ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            probedQ <= 1'b0;
        end else begin
            probedQ <= (state == VIC_PROBE) && !probedQ;
        end
    end

    assign vic_probe = (state == VIC_PROBE) && !probedQ;
`else
    logic unusedVic;
    assign unusedVic = ^{vic_hit, vic_data};
    assign vic_probe = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (req_valid) stateNext = LOOKUP;
            end
            LOOKUP: begin
                if (hitAny) begin
                    stateNext = IDLE;
                end else begin
`ifdef GT_ASSOC_CACHE_VICTIM_EN
                    stateNext = VIC_PROBE;
`else
                    stateNext = MEM_REQ;
`endif
                end
            end
            VIC_PROBE: begin
`ifdef GT_ASSOC_CACHE_VICTIM_EN
                if (probedQ) stateNext = vic_hit ? FILL : MEM_REQ;
`else
                stateNext = MEM_REQ;
`endif
            end
            MEM_REQ: begin
                if (mem_req_ready) stateNext = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_fill_valid) stateNext = FILL;
            end
            FILL: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addrQ       <= '0;
            lineQ       <= '0;
            respValidQ  <= 1'b0;
            respHitQ    <= 1'b0;
            respDataQ   <= '0;
            evictValidQ <= 1'b0;
            evictAddrQ  <= '0;
            evictDataQ  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    validQ[s][w] <= 1'b0;
                end
            end
        end else begin
            respValidQ  <= 1'b0;
            respHitQ    <= 1'b0;
            respDataQ   <= '0;
            evictValidQ <= 1'b0;
            evictAddrQ  <= '0;
            evictDataQ  <= '0;
            if (state == IDLE && req_valid) begin
                addrQ <= req_addr;
            end
            if (state == LOOKUP && hitAny) begin
                respValidQ <= 1'b1;
                respHitQ   <= 1'b1;
                respDataQ  <= getByte(dataQ[reqIdx][hitWay], reqOff);
            end
            if (state == MEM_WAIT && mem_fill_valid) begin
                lineQ <= mem_fill_data;
            end
`ifdef GT_ASSOC_CACHE_VICTIM_EN
            if (state == VIC_PROBE && probedQ && vic_hit) begin
                lineQ <= vic_data;
            end
`endif
            if (state == FILL) begin
                respValidQ <= 1'b1;
                respDataQ  <= getByte(lineQ, reqOff);
                if (validQ[reqIdx][fillWay]) begin
                    evictValidQ <= 1'b1;
                    evictAddrQ  <= {tagQ[reqIdx][fillWay], reqIdx,
                                    {OFF_W{1'b0}}};
                    evictDataQ  <= dataQ[reqIdx][fillWay];
                end
                validQ[reqIdx][fillWay] <= 1'b1;
            end
        end
    end

    // Tag and data storage need no reset; valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (state == FILL) begin
            tagQ[reqIdx][fillWay]  <= reqTag;
            dataQ[reqIdx][fillWay] <= lineQ;
        end
    end

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == MEM_REQ);
    assign mem_req_addr  = (state == MEM_REQ || state == VIC_PROBE)
                           ? lineAddr : '0;
    assign resp_valid    = respValidQ;
    assign resp_hit      = respHitQ;
    assign resp_data     = respDataQ;
    assign evict_valid   = evictValidQ;
    assign evict_addr    = evictAddrQ;
    assign evict_data    = evictDataQ;

endmodule

// File: tb/tb_gt_assoc_cache.sv
// tb_gt_assoc_cache: directed and random accesses against a
// timestamp-LRU cache model with a memory and victim-store model.
module tb_gt_assoc_cache;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         resp_valid;
    logic [7:0]   resp_data;
    logic         resp_hit;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_fill_valid;
    logic [255:0] mem_fill_data;
    logic         evict_valid;
    logic [31:0]  evict_addr;
    logic [255:0] evict_data;
    logic         vic_probe;
    logic         vic_hit;
    logic [255:0] vic_data;

    always #5 CLK = ~CLK;

    gt_assoc_cache dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_hit       (resp_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_fill_valid (mem_fill_valid),
        .mem_fill_data  (mem_fill_data),
        .evict_valid    (evict_valid),
        .evict_addr     (evict_addr),
        .evict_data     (evict_data),
        .vic_probe      (vic_probe),
        .vic_hit        (vic_hit),
        .vic_data       (vic_data)
    );

    int nCmp = 0;
    int nBad = 0;

    task automatic checkVal(input string tag, input logic [255:0] got,
                            input logic [255:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: 16 sets x 2 ways, LRU by last-use timestamp.
    bit           mValid [16][2];
    logic [22:0]  mTag   [16][2];
    logic [255:0] mLine  [16][2];
    longint       mUse   [16][2];
    longint       now = 0;
    logic [255:0] vicStore [logic [31:0]];
    bit           countMode = 0;

    bit           lastHit;
    logic [7:0]   lastData;
    logic [31:0]  lastEvAddr;
    int           lastEvCnt;
    int           lastMemReqs;

    function automatic logic [255:0] memLine(input logic [31:0] la);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) begin
            r[k*8 +: 8] = countMode ? 8'(k)
                : 8'(k * 3 + int'(la[12:5]) * 11 + int'(la[20:13]) * 5 + 1);
        end
        return r;
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                mValid[s][w] = 0;
                mUse[s][w]   = 0;
            end
        end
        vicStore.delete();
    endtask

    task automatic access(input logic [31:0] a, input int hold);
        int s, off, hw, fw, cyc, respCyc, nResp, nEv, nMem, reqCnt, vicCnt;
        bit expHit, expEv, expVic, pendingFill;
        logic [22:0]  t;
        logic [31:0]  la, evAddr;
        logic [255:0] expLine, evLine;
        s = int'(a[8:5]);
        off = int'(a[4:0]);
        t = a[31:9];
        la = {a[31:5], 5'b0};
        hw = -1;
        fw = -1;
        expEv = 0;
        expVic = 0;
        evAddr = '0;
        evLine = '0;
        for (int w = 0; w < 2; w++) begin
            if (mValid[s][w] && mTag[s][w] == t) hw = w;
        end
        expHit = (hw >= 0);
        if (expHit) begin
            expLine = mLine[s][hw];
        end else begin
            for (int w = 1; w >= 0; w--) begin
                if (!mValid[s][w]) fw = w;
            end
            if (fw < 0) fw = (mUse[s][0] < mUse[s][1]) ? 0 : 1;
            expEv = mValid[s][fw];
            evAddr = {mTag[s][fw], 4'(s), 5'b0};
            evLine = mLine[s][fw];
`ifdef GT_ASSOC_CACHE_VICTIM_EN
            expVic = vicStore.exists(la);
`endif
            expLine = expVic ? vicStore[la] : memLine(la);
        end

        checkVal("ready_before_req", req_ready, 1);
        req_valid = 1;
        req_addr = a;
        @(posedge CLK);
        #1 req_valid = 0;

        cyc = 0; respCyc = -1; nResp = 0; nEv = 0; nMem = 0;
        reqCnt = 0; vicCnt = 0; pendingFill = 0;
        lastEvAddr = '0;
        while (nResp == 0 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (mem_fill_valid) mem_fill_valid = 0;
            if (vicCnt > 0) begin
                vicCnt--;
                if (vicCnt == 0) begin
                    vic_hit = 0;
                    vic_data = '0;
                end
            end
            if (pendingFill) begin
                pendingFill = 0;
                mem_req_ready = 0;
                mem_fill_valid = 1;
                mem_fill_data = memLine(la);
            end
            if (vic_probe) begin
                checkVal("vic_probe_addr", mem_req_addr, la);
                vic_hit = expVic;
                vic_data = expVic ? vicStore[la] : '0;
                vicCnt = 2;
            end
            if (mem_req_valid) begin
                nMem++;
                reqCnt++;
                checkVal("mem_req_addr", mem_req_addr, la);
                if (reqCnt > hold) begin
                    mem_req_ready = 1;
                    pendingFill = 1;
                end
            end
            if (evict_valid) begin
                nEv++;
                lastEvAddr = evict_addr;
                checkVal("evict_addr", evict_addr, evAddr);
                checkVal("evict_data", evict_data, evLine);
            end
            if (resp_valid) begin
                nResp++;
                respCyc = cyc;
                lastHit = resp_hit;
                lastData = resp_data;
                checkVal("resp_hit", resp_hit, expHit);
                checkVal("resp_data", resp_data, expLine[off*8 +: 8]);
                checkVal("ready_at_resp", req_ready, 1);
            end
        end
        if (nResp == 0) checkVal("resp_timeout", 0, 1);
        checkVal("evict_count", nEv, (!expHit && expEv) ? 1 : 0);
        checkVal("mem_req_cycles", nMem,
                 (expHit || expVic) ? 0 : hold + 1);
        if (expHit) checkVal("hit_latency", respCyc, 2);
        lastEvCnt = nEv;
        lastMemReqs = nMem;
        vic_hit = 0;
        vic_data = '0;
        @(negedge CLK);
        checkVal("pulse_width", {resp_valid, evict_valid}, 0);

        now++;
        if (expHit) begin
            mUse[s][hw] = now;
        end else begin
            if (expEv) vicStore[evAddr] = evLine;
            mValid[s][fw] = 1;
            mTag[s][fw] = t;
            mLine[s][fw] = expLine;
            mUse[s][fw] = now;
        end
    endtask

    task automatic resetDut();
        RST = 1;
        repeat (2) @(negedge CLK);
        RST = 0;
        modelReset();
        @(negedge CLK);
    endtask

    initial begin
        int cyc;
        logic [31:0] a;
        RST = 1;
        req_valid = 0;
        req_addr = '0;
        mem_req_ready = 0;
        mem_fill_valid = 0;
        mem_fill_data = '0;
        vic_hit = 0;
        vic_data = '0;
        modelReset();
        repeat (3) @(negedge CLK);
        checkVal("rst_req_ready", req_ready, 1);
        checkVal("rst_outputs",
                 {resp_valid, resp_hit, resp_data, mem_req_valid,
                  mem_req_addr, evict_valid, evict_addr, vic_probe}, 0);
        checkVal("rst_evict_data", evict_data, 0);
        RST = 0;
        @(negedge CLK);

        countMode = 1;
        access(32'h0000_0123, 0);
        countMode = 0;
        checkVal("first_miss_hit", lastHit, 0);
        checkVal("first_miss_data", lastData, 8'h03);
        checkVal("first_miss_evict", lastEvCnt, 0);

        access(32'h0000_0123, 0);
        checkVal("repeat_hit", lastHit, 1);
        checkVal("repeat_data", lastData, 8'h03);
        checkVal("repeat_no_mem", lastMemReqs, 0);

        resetDut();
        access(32'h0000_0000, 0);
        access(32'h0000_0200, 1);
        access(32'h0000_0004, 0);
        access(32'h0000_0400, 2);
        checkVal("lru_evict_count", lastEvCnt, 1);
        checkVal("lru_evict_addr", lastEvAddr, 32'h0000_0200);

        access(32'h0000_0207, 0);
        checkVal("refetch_hit", lastHit, 0);
`ifdef GT_ASSOC_CACHE_VICTIM_EN
        checkVal("vic_no_mem", lastMemReqs, 0);
`endif
        access(32'h0000_021f, 0);
        checkVal("refetch_then_hit", lastHit, 1);

        access(32'h0000_0611, 5);
        checkVal("hold_mem_cycles", lastMemReqs, 6);
        mem_fill_valid = 1;
        mem_fill_data = {8{32'hdead_beef}};
        @(negedge CLK);
        mem_fill_valid = 0;
        mem_fill_data = '0;
        repeat (3) begin
            @(negedge CLK);
            checkVal("stray_fill_quiet",
                     {req_ready, resp_valid, evict_valid, mem_req_valid},
                     4'b1000);
        end
        access(32'h0000_0611, 0);
        checkVal("after_stray_hit", lastHit, 1);

        a = 32'h0000_1a48;
        access(32'h0000_1a40, 0);
        resetDut();
        req_valid = 1;
        req_addr = a;
        @(posedge CLK);
        #1 req_valid = 0;
        cyc = 0;
        while (!mem_req_valid && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        if (!mem_req_valid) checkVal("reset_miss_timeout", 0, 1);
        mem_req_ready = 1;
        @(negedge CLK);
        mem_req_ready = 0;
        RST = 1;
        @(negedge CLK);
        RST = 0;
        modelReset();
        mem_fill_valid = 1;
        mem_fill_data = memLine({a[31:5], 5'b0});
        @(negedge CLK);
        mem_fill_valid = 0;
        repeat (4) begin
            @(negedge CLK);
            checkVal("abandoned_quiet",
                     {req_ready, resp_valid, evict_valid, mem_req_valid},
                     4'b1000);
        end
        access(a, 0);
        checkVal("after_reset_miss", lastHit, 0);

        for (int i = 0; i < 300; i++) begin
            a = {20'h0, 3'($urandom_range(0, 5)), 2'b00,
                 2'($urandom_range(0, 3)), 5'($urandom)};
            access(a, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
